// File: rtl/fme_search_sequencer.sv
// fme_search_sequencer
//
// Control block between interpolation and search in the FME datapath.
// Accepts framed rows from upstream and gates the interpolator. It
// regenerates the search enable as a delayed copy of the accepted rows, with
// bubbles preserved, and counts search rows per block. It then waits out the
// search pipeline drain and captures the best SAD and address of the block.
//
// Handshake: `enable` is a valid-only qualifier with no back-pressure.
// `enable_interp` is high in exactly the cycles whose `enable` row (or start)
// is taken. Rows offered when not taken are dropped.
//
// Ports
//   clock, reset        rising-edge clock, async active-high reset
//   enable, block_start upstream row valid / row-0 marker
//   best_sad_ime        IME SAD, latched on an accepted start
//   search_best_sad     search result SAD, captured at the end of drain
//   search_address      search result address, captured with the SAD
//   enable_interp       combinational row/start accept
//   enable_search       registered search enable (tail of the delay line)
//   best_sad_ime_q      latched IME SAD for the current block
//   search_row          index of the current search row
//   busy                FSM not idle
//   result_valid        one-cycle pulse, one cycle after capture
//   best_sad            captured SAD (held)
//   address_best_sad    captured address (held)
//   protocol_error      sticky: start requested while a block is in flight
//
// Optional feature: define FME_SEQ_STATS_EN to add the blocks_done
// (wrapping) and stall_cycles (saturating) counters.

module fme_search_sequencer #(
    parameter int DATAWIDTH     = 8,
    parameter int ROWS          = 8,
    parameter int ROW_W         = 3,
    parameter int FILL_LATENCY  = 3,
    parameter int DRAIN_LATENCY = 4,
    parameter int LAT_W         = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 block_start,
    input  logic [DATAWIDTH+8:0] best_sad_ime,
    input  logic [DATAWIDTH+8:0] search_best_sad,
    input  logic [5:0]           search_address,
    output logic                 enable_interp,
    output logic                 enable_search,
    output logic [DATAWIDTH+8:0] best_sad_ime_q,
    output logic [ROW_W-1:0]     search_row,
    output logic                 busy,
    output logic                 result_valid,
    output logic [DATAWIDTH+8:0] best_sad,
    output logic [5:0]           address_best_sad,
    output logic                 protocol_error
`ifdef FME_SEQ_STATS_EN
    ,
    output logic [15:0]          blocks_done,
    output logic [15:0]          stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // in_cnt needs one extra bit so it can hold ROWS itself.
    localparam logic [ROW_W:0]   ROWS_C     = (ROW_W+1)'(ROWS);
    localparam logic [ROW_W:0]   CNT_ONE    = (ROW_W+1)'(1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
    localparam logic [LAT_W-1:0] DRAIN_LOAD = LAT_W'(DRAIN_LATENCY - 1);
    localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);

    state_t                  state_q, state_d;
    logic [ROW_W:0]          in_cnt_q, in_cnt_d;
    logic [FILL_LATENCY-1:0] fill_q, fill_d;
    logic [ROW_W-1:0]        search_row_q, search_row_d;
    logic [LAT_W-1:0]        drain_cnt_q, drain_cnt_d;
    logic [DATAWIDTH+8:0]    best_sad_ime_d;
    logic [DATAWIDTH+8:0]    best_sad_q, best_sad_d;
    logic [5:0]              address_q, address_d;
    logic                    result_valid_q, result_valid_d;
    logic                    protocol_error_q, protocol_error_d;
`ifdef FME_SEQ_STATS_EN
    logic [15:0]             blocks_done_q, blocks_done_d;
    logic [15:0]             stall_cycles_q, stall_cycles_d;
`endif

    logic final_drain;
    logic start_req;
    logic start_acc;
    logic row_acc;
    logic last_search;

    // A new block may begin on the last drain cycle. That cycle captures
    // the old result and seeds the new block, so consecutive blocks have
    // no dead cycle between them.
    assign final_drain = (state_q == DRAIN) && (drain_cnt_q == '0);
    assign start_req   = enable && block_start;
    assign start_acc   = start_req && ((state_q == IDLE) || final_drain);
    // A start requested in RUN is an error, but its row still counts
    // toward the block.
    assign row_acc     = (state_q == RUN) && enable && (in_cnt_q < ROWS_C);
    assign last_search = enable_search && (search_row_q == LAST_ROW);

    assign enable_interp    = start_acc || row_acc;
    assign enable_search    = fill_q[FILL_LATENCY-1];
    assign search_row       = search_row_q;
    assign busy             = (state_q != IDLE);
    assign result_valid     = result_valid_q;
    assign best_sad         = best_sad_q;
    assign address_best_sad = address_q;
    assign protocol_error   = protocol_error_q;
`ifdef FME_SEQ_STATS_EN
    assign blocks_done      = blocks_done_q;
    assign stall_cycles     = stall_cycles_q;
`endif

    always_comb begin
        state_d          = state_q;
        in_cnt_d         = in_cnt_q;
        search_row_d     = search_row_q;
        drain_cnt_d      = drain_cnt_q;
        best_sad_ime_d   = best_sad_ime_q;
        best_sad_d       = best_sad_q;
        address_d        = address_q;
        result_valid_d   = 1'b0;
        protocol_error_d = protocol_error_q;

        // Accept history; every cycle shifts, so stalls appear as zeros.
        fill_d[0] = start_acc || row_acc;
        for (int i = 1; i < FILL_LATENCY; i++) begin
            fill_d[i] = fill_q[i-1];
        end

        if (enable_search) begin
            search_row_d = last_search ? '0 : search_row_q + ROW_ONE;
        end

        if (start_acc) begin
            in_cnt_d       = CNT_ONE;
            best_sad_ime_d = best_sad_ime;
        end else if (row_acc) begin
            in_cnt_d = in_cnt_q + CNT_ONE;
        end

        if (start_req && ((state_q == RUN) || ((state_q == DRAIN) && !final_drain))) begin
            protocol_error_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_search) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (final_drain) begin
                    best_sad_d     = search_best_sad;
                    address_d      = search_address;
                    result_valid_d = 1'b1;
                    state_d        = start_acc ? RUN : IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - LAT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FME_SEQ_STATS_EN
    always_comb begin
        blocks_done_d  = blocks_done_q + (result_valid_q ? 16'd1 : 16'd0);
        stall_cycles_d = stall_cycles_q;
        if ((state_q == RUN) && !enable && (in_cnt_q < ROWS_C) && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            in_cnt_q         <= '0;
            fill_q           <= '0;
            search_row_q     <= '0;
            drain_cnt_q      <= '0;
            best_sad_ime_q   <= '0;
            best_sad_q       <= '0;
            address_q        <= '0;
            result_valid_q   <= 1'b0;
            protocol_error_q <= 1'b0;
`ifdef FME_SEQ_STATS_EN
            blocks_done_q    <= '0;
            stall_cycles_q   <= '0;
`endif
        end else begin
            state_q          <= state_d;
            in_cnt_q         <= in_cnt_d;
            fill_q           <= fill_d;
            search_row_q     <= search_row_d;
            drain_cnt_q      <= drain_cnt_d;
            best_sad_ime_q   <= best_sad_ime_d;
            best_sad_q       <= best_sad_d;
            address_q        <= address_d;
            result_valid_q   <= result_valid_d;
            protocol_error_q <= protocol_error_d;
`ifdef FME_SEQ_STATS_EN
            blocks_done_q    <= blocks_done_d;
            stall_cycles_q   <= stall_cycles_d;
`endif
        end
    end

endmodule
